seq_alu: RTL

Parametrised, registered successor to the team's 8-bit combinational ALU. It keeps the same 3-bit opcode map. Operand width is generalised to WIDTH. Results are registered, and the block reports zero, carry and overflow flags. Both multiplies are iterative shift-add sequences, and valid/ready handshakes sit on both sides so the block can drop into a pipelined datapath.

---
 rtl/seq_alu.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshakes on both sides.
// Logic ops, add and subtract complete one edge after acceptance. The two
// multiplies (opcode 100 = half-width, 110 = full-width truncated) run as
// iterative shift-add sequences before the result is presented.
//
// Optional build macro: SEQ_ALU_HI_RESULT_EN adds out_hi, which carries the
// upper WIDTH bits of the full product for opcode 110 and is 0 otherwise.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand/opcode valid
//   in_ready   block can accept an operation (IDLE only)
//   A, B       operands, WIDTH bits
//   opcode     operation select (3 bits)
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts result
//   out        result, WIDTH bits
//   zero_f     out == 0
//   carry_f    carry / borrow / product truncation
//   ovf_f      signed overflow (add/sub only)
//   out_hi     (macro only) upper product half for opcode 110
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero_f,
  output logic             carry_f,
  output logic             ovf_f
`ifdef SEQ_ALU_HI_RESULT_EN
  ,
  output logic [WIDTH-1:0] out_hi
`endif
);

  localparam int HW = WIDTH / 2;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_full;

  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH-1:0]     w_res;
  logic                 w_c;
  logic                 w_v;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [WIDTH-1:0]     w_mul_lo;
  logic                 w_mul_c;

  assign w_sum  = {1'b0, A} + {1'b0, B};
  assign w_diff = {1'b0, A} - {1'b0, B};

  // Single-cycle result for the non-multiply opcodes.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (opcode)
      3'b000: w_res = ~A;
      3'b001: w_res = A | B;
      3'b010: w_res = A ^ B;
      3'b011: w_res = A & B;
      3'b101: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      3'b111: begin
        w_res = w_diff[WIDTH-1:0];
        // The extra top bit of the widened difference is the borrow.
        w_c   = w_diff[WIDTH];
        w_v   = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      default: ;
    endcase
  end

  // One shift-add step; the final step's value is registered directly so
  // the result lands on the same edge the counter reaches zero.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_lo   = w_acc_next[WIDTH-1:0];
  assign w_mul_c    = r_full && (|w_acc_next[2*WIDTH-1:WIDTH]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_full    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      zero_f    <= 1'b0;
      carry_f   <= 1'b0;
      ovf_f     <= 1'b0;
`ifdef SEQ_ALU_HI_RESULT_EN
      out_hi    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (opcode == 3'b100 || opcode == 3'b110) begin
              r_acc  <= '0;
              r_full <= opcode[1];
              if (opcode[1]) begin
                r_mcand  <= {{WIDTH{1'b0}}, A};
                r_mplier <= B;
                r_cnt    <= CNT_W'(WIDTH);
              end else begin
                // Half-width multiply: operands are the zero-extended low halves.
                r_mcand  <= {{(WIDTH + HW){1'b0}}, A[HW-1:0]};
                r_mplier <= {{(WIDTH - HW){1'b0}}, B[HW-1:0]};
                r_cnt    <= CNT_W'(HW);
              end
              r_state <= S_MUL;
            end else begin
              out       <= w_res;
              zero_f    <= (w_res == '0);
              carry_f   <= w_c;
              ovf_f     <= w_v;
`ifdef SEQ_ALU_HI_RESULT_EN
              out_hi    <= '0;
`endif
              out_valid <= 1'b1;
              r_state   <= S_DONE;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            out       <= w_mul_lo;
            zero_f    <= (w_mul_lo == '0);
            carry_f   <= w_mul_c;
            ovf_f     <= 1'b0;
`ifdef SEQ_ALU_HI_RESULT_EN
            out_hi    <= r_full ? w_acc_next[2*WIDTH-1:WIDTH] : '0;
`endif
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
